// File: rtl/lieat_ifu_bpu_if.sv
// Fetch-side branch prediction bus: fetch lookup, execute-stage branch
// resolution and the redirect toward the fetch PC generator.
interface lieat_ifu_bpu_if #(
   parameter int XLEN    = 32,
   parameter int BHT_IDX = 5
);
   // fetch lookup request
   logic               ifu_req_valid;
   logic               ifu_req_ready;
   logic [XLEN-1:0]    ifu_req_pc;
   logic               ifu_req_bxx;
   logic [XLEN-1:0]    ifu_req_imm;
   // registered prediction
   logic               ifu_rsp_valid;
   logic               ifu_rsp_ready;
   logic               ifu_rsp_taken;
   logic [XLEN-1:0]    ifu_rsp_pc;
   // branch resolution from execute
   logic               bjp_prdt_en;
   logic [BHT_IDX-1:0] bjp_prdt_index;
   logic               bjp_prdt_res;
   logic               bjp_prdt_flush;
   logic [XLEN-1:0]    bjp_prdt_pc;
   // redirect toward the PC generator
   logic               bpu_redirect_valid;
   logic               bpu_redirect_ready;
   logic [XLEN-1:0]    bpu_redirect_pc;
   logic [31:0]        bpu_mispred_cnt;

   // environment side: fetch, execute and PC generator
   modport master (
      output ifu_req_valid, ifu_req_pc, ifu_req_bxx, ifu_req_imm,
      input  ifu_req_ready,
      input  ifu_rsp_valid, ifu_rsp_taken, ifu_rsp_pc,
      output ifu_rsp_ready,
      output bjp_prdt_en, bjp_prdt_index, bjp_prdt_res, bjp_prdt_flush, bjp_prdt_pc,
      input  bpu_redirect_valid, bpu_redirect_pc, bpu_mispred_cnt,
      output bpu_redirect_ready
   );

   // predictor side
   modport slave (
      input  ifu_req_valid, ifu_req_pc, ifu_req_bxx, ifu_req_imm,
      output ifu_req_ready,
      output ifu_rsp_valid, ifu_rsp_taken, ifu_rsp_pc,
      input  ifu_rsp_ready,
      input  bjp_prdt_en, bjp_prdt_index, bjp_prdt_res, bjp_prdt_flush, bjp_prdt_pc,
      output bpu_redirect_valid, bpu_redirect_pc, bpu_mispred_cnt,
      input  bpu_redirect_ready
   );
endinterface

// File: rtl/lieat_ifu_bpu.sv
// Bimodal branch predictor: 2-bit saturating counter table indexed by
// pc[BHT_IDX+1:2], one registered lookup per cycle, training from resolved
// branches with same-cycle bypass, and a held misprediction redirect.
module lieat_ifu_bpu #(
   parameter int XLEN    = 32,
   parameter int BHT_IDX = 5
) (
   input logic          clock,
   input logic          reset,
   lieat_ifu_bpu_if.slave bus
);
   localparam int DEPTH = 1 << BHT_IDX;

   // Saturating step of a 2-bit direction counter.
   function automatic logic [1:0] sat_step(input logic [1:0] c, input logic up);
      if (up) return (c == 2'b11) ? c : c + 2'b01;
      else    return (c == 2'b00) ? c : c - 2'b01;
   endfunction

   logic [1:0]         ctr_q [DEPTH];
   logic [1:0]         ctr_d [DEPTH];
   logic               rsp_valid_q, rsp_valid_d;
   logic               rsp_taken_q, rsp_taken_d;
   logic [XLEN-1:0]    rsp_pc_q, rsp_pc_d;
   logic               redir_valid_q, redir_valid_d;
   logic [XLEN-1:0]    redir_pc_q, redir_pc_d;
   logic [31:0]        cnt_q, cnt_d;

   logic               req_ready;
   logic               accept;
   logic [BHT_IDX-1:0] lk_idx;
   logic [1:0]         lk_ctr;
   logic               lk_taken;
   logic [XLEN-1:0]    lk_pc;

   // Fetch is stalled while a redirect is owed, during a flush, or while the
   // response slot is occupied and not being drained.
   assign req_ready = ~redir_valid_q & ~bus.bjp_prdt_flush
                    & (~rsp_valid_q | bus.ifu_rsp_ready);
   assign accept    = bus.ifu_req_valid & req_ready;

   // Table training; ctr_d is also the bypassed view used by the lookup.
   always_comb begin
      ctr_d = ctr_q;
      if (bus.bjp_prdt_en)
         ctr_d[bus.bjp_prdt_index] = sat_step(ctr_q[bus.bjp_prdt_index], bus.bjp_prdt_res);
   end

   // Lookup: direction from counter MSB, target from predecoded offset.
   always_comb begin
      lk_idx   = bus.ifu_req_pc[BHT_IDX+1:2];
      lk_ctr   = ctr_d[lk_idx];
      lk_taken = bus.ifu_req_bxx & lk_ctr[1];
      lk_pc    = lk_taken ? bus.ifu_req_pc + bus.ifu_req_imm
                          : bus.ifu_req_pc + XLEN'(4);
   end

   // Response slot, redirect register and mispredict counter next state.
   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_taken_d = rsp_taken_q;
      rsp_pc_d    = rsp_pc_q;
      if (bus.bjp_prdt_flush) begin
         rsp_valid_d = 1'b0;
      end else if (accept) begin
         rsp_valid_d = 1'b1;
         rsp_taken_d = lk_taken;
         rsp_pc_d    = lk_pc;
      end else if (bus.ifu_rsp_ready) begin
         rsp_valid_d = 1'b0;
      end

      redir_valid_d = redir_valid_q;
      redir_pc_d    = redir_pc_q;
      if (bus.bjp_prdt_flush) begin
         // newest flush wins, even against a completing handshake
         redir_valid_d = 1'b1;
         redir_pc_d    = bus.bjp_prdt_pc;
      end else if (redir_valid_q & bus.bpu_redirect_ready) begin
         redir_valid_d = 1'b0;
      end

      cnt_d = cnt_q + {31'd0, bus.bjp_prdt_flush};
   end

   // State registers, asynchronously reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) ctr_q[i] <= 2'b01;
         rsp_valid_q   <= 1'b0;
         rsp_taken_q   <= 1'b0;
         rsp_pc_q      <= '0;
         redir_valid_q <= 1'b0;
         redir_pc_q    <= '0;
         cnt_q         <= '0;
      end else begin
         ctr_q         <= ctr_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_taken_q   <= rsp_taken_d;
         rsp_pc_q      <= rsp_pc_d;
         redir_valid_q <= redir_valid_d;
         redir_pc_q    <= redir_pc_d;
         cnt_q         <= cnt_d;
      end
   end

   assign bus.ifu_req_ready      = req_ready;
   assign bus.ifu_rsp_valid      = rsp_valid_q;
   assign bus.ifu_rsp_taken      = rsp_taken_q;
   assign bus.ifu_rsp_pc         = rsp_pc_q;
   assign bus.bpu_redirect_valid = redir_valid_q;
   assign bus.bpu_redirect_pc    = redir_pc_q;
   assign bus.bpu_mispred_cnt    = cnt_q;
endmodule

// File: tb/tb_lieat_ifu_bpu.sv
// Bench for lieat_ifu_bpu: directed scenarios followed by random traffic,
// all compared against a cycle-level reference model of the predictor.
module tb_lieat_ifu_bpu;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   lieat_ifu_bpu_if #(.XLEN(32), .BHT_IDX(5)) bus ();
   lieat_ifu_bpu #(.XLEN(32), .BHT_IDX(5)) dut (.clock(clk), .reset(rst), .bus(bus));

   int n_chk = 0;
   int n_err = 0;

   // reference model state
   int          m_ctr [32];
   logic        m_rspv, m_tk, m_rv;
   logic [31:0] m_rpc, m_rdpc, m_cnt;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < 32; i++) m_ctr[i] = 1;
      m_rspv = 0; m_tk = 0; m_rpc = 0; m_rv = 0; m_rdpc = 0; m_cnt = 0;
   endtask

   task automatic idle();
      bus.ifu_req_valid = 0; bus.ifu_req_pc = 0; bus.ifu_req_bxx = 0; bus.ifu_req_imm = 0;
      bus.ifu_rsp_ready = 1;
      bus.bjp_prdt_en = 0; bus.bjp_prdt_index = 0; bus.bjp_prdt_res = 0;
      bus.bjp_prdt_flush = 0; bus.bjp_prdt_pc = 0;
      bus.bpu_redirect_ready = 0;
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".rsp_valid"}, bus.ifu_rsp_valid, m_rspv);
      chk({tag, ".rsp_taken"}, bus.ifu_rsp_taken, m_tk);
      chk({tag, ".rsp_pc"}, bus.ifu_rsp_pc, m_rpc);
      chk({tag, ".redir_valid"}, bus.bpu_redirect_valid, m_rv);
      chk({tag, ".redir_pc"}, bus.bpu_redirect_pc, m_rdpc);
      chk({tag, ".mispred_cnt"}, bus.bpu_mispred_cnt, m_cnt);
   endtask

   // One clock: check ready against the model, clock the edge, advance the
   // model from the inputs that were applied, then compare all outputs.
   task automatic cycle(input string tag);
      logic rdy, acc, tk;
      int   lidx, c, ti;
      logic [31:0] npc;
      #1;
      rdy = !m_rv && !bus.bjp_prdt_flush && (!m_rspv || bus.ifu_rsp_ready);
      chk({tag, ".req_ready"}, bus.ifu_req_ready, rdy);
      acc  = bus.ifu_req_valid && rdy;
      lidx = int'(bus.ifu_req_pc[6:2]);
      ti   = int'(bus.bjp_prdt_index);
      // training outcome of this cycle, visible to a same-index lookup
      c = m_ctr[lidx];
      if (bus.bjp_prdt_en && ti == lidx)
         c = bus.bjp_prdt_res ? ((c == 3) ? 3 : c + 1) : ((c == 0) ? 0 : c - 1);
      tk  = bus.ifu_req_bxx && (c >= 2);
      npc = tk ? bus.ifu_req_pc + bus.ifu_req_imm : bus.ifu_req_pc + 32'd4;
      @(posedge clk);
      if (bus.bjp_prdt_en)
         m_ctr[ti] = bus.bjp_prdt_res ? ((m_ctr[ti] == 3) ? 3 : m_ctr[ti] + 1)
                                      : ((m_ctr[ti] == 0) ? 0 : m_ctr[ti] - 1);
      if (bus.bjp_prdt_flush)       m_rspv = 0;
      else if (acc)                 begin m_rspv = 1; m_tk = tk; m_rpc = npc; end
      else if (bus.ifu_rsp_ready)   m_rspv = 0;
      if (bus.bjp_prdt_flush)       begin m_rv = 1; m_rdpc = bus.bjp_prdt_pc; end
      else if (m_rv && bus.bpu_redirect_ready) m_rv = 0;
      if (bus.bjp_prdt_flush)       m_cnt = m_cnt + 32'd1;
      #1;
      check_outputs(tag);
   endtask

   task automatic lookup(input logic [31:0] pc, input logic bxx, input logic [31:0] imm);
      bus.ifu_req_valid = 1; bus.ifu_req_pc = pc; bus.ifu_req_bxx = bxx; bus.ifu_req_imm = imm;
   endtask

   task automatic train(input int idx, input logic res);
      bus.bjp_prdt_en = 1; bus.bjp_prdt_index = 5'(idx); bus.bjp_prdt_res = res;
   endtask

   initial begin
      m_reset();
      idle();
      rst = 1;
      repeat (2) @(posedge clk);
      #1;
      check_outputs("reset");
      rst = 0;

      // cold lookup predicts not-taken
      lookup(32'h8000_0010, 1, 32'h40);
      cycle("tp1");
      chk("tp1_taken", bus.ifu_rsp_taken, 0);
      chk("tp1_pc", bus.ifu_rsp_pc, 32'h8000_0014);
      idle();

      // train index 4 up to strongly taken
      train(4, 1); cycle("tr_up0");
      train(4, 1); cycle("tr_up1");
      idle();
      lookup(32'h10, 1, 32'hFFFF_FFF0);
      cycle("tp2");
      chk("tp2_taken", bus.ifu_rsp_taken, 1);
      chk("tp2_pc", bus.ifu_rsp_pc, 32'h0);
      idle();
      // down to 00 and one more to confirm the floor
      for (int i = 0; i < 4; i++) begin
         train(4, 0); cycle("tr_dn");
      end
      // from 00 a bypassed up-step only reaches 01: still not taken
      train(4, 1); lookup(32'h10, 1, 32'h40);
      cycle("tp2_floor");
      chk("tp2_floor_taken", bus.ifu_rsp_taken, 0);
      chk("tp2_floor_pc", bus.ifu_rsp_pc, 32'h14);
      idle();

      // bypass from 01: training in the lookup cycle makes it taken
      train(4, 1); lookup(32'h10, 1, 32'h40);
      cycle("tp3");
      chk("tp3_taken", bus.ifu_rsp_taken, 1);
      chk("tp3_pc", bus.ifu_rsp_pc, 32'h50);
      idle();
      lookup(32'h10, 0, 32'h40);
      cycle("tp3b");
      chk("tp3b_taken", bus.ifu_rsp_taken, 0);
      chk("tp3b_pc", bus.ifu_rsp_pc, 32'h14);
      idle();
      cycle("drain");

      // backpressure on the response slot
      bus.ifu_rsp_ready = 0;
      lookup(32'h20, 0, 32'h0);
      cycle("tp4_acc");
      lookup(32'h30, 0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         cycle("tp4_hold");
         chk("tp4_ready_low", bus.ifu_req_ready, 0);
         chk("tp4_hold_pc", bus.ifu_rsp_pc, 32'h24);
      end
      bus.ifu_rsp_ready = 1;
      cycle("tp4_rel");
      chk("tp4_new_valid", bus.ifu_rsp_valid, 1);
      chk("tp4_new_pc", bus.ifu_rsp_pc, 32'h34);
      idle();
      cycle("drain");

      // flush while a response is pending
      bus.ifu_rsp_ready = 0;
      lookup(32'h40, 0, 32'h0);
      cycle("tp5_acc");
      idle(); bus.ifu_rsp_ready = 0;
      bus.bjp_prdt_flush = 1; bus.bjp_prdt_pc = 32'h100;
      cycle("tp5_fl1");
      chk("tp5_rsp_dropped", bus.ifu_rsp_valid, 0);
      chk("tp5_redir_v", bus.bpu_redirect_valid, 1);
      chk("tp5_redir_pc", bus.bpu_redirect_pc, 32'h100);
      bus.bjp_prdt_pc = 32'h200;
      cycle("tp5_fl2");
      chk("tp5_redir_pc2", bus.bpu_redirect_pc, 32'h200);
      chk("tp5_cnt", bus.bpu_mispred_cnt, 2);
      idle(); bus.bpu_redirect_ready = 1;
      cycle("tp5_hs");
      chk("tp5_redir_clr", bus.bpu_redirect_valid, 0);
      idle(); lookup(32'h50, 0, 32'h0);
      #1 chk("tp5_req_ready", bus.ifu_req_ready, 1);
      cycle("tp5_resume");
      idle();

      // flush coinciding with the redirect handshake
      bus.bjp_prdt_flush = 1; bus.bjp_prdt_pc = 32'h280;
      cycle("tp6_fl");
      bus.bjp_prdt_pc = 32'h300; bus.bpu_redirect_ready = 1;
      cycle("tp6_hs_fl");
      chk("tp6_redir_v", bus.bpu_redirect_valid, 1);
      chk("tp6_redir_pc", bus.bpu_redirect_pc, 32'h300);
      idle();

      // asynchronous reset with a redirect pending, away from any edge
      rst = 1;
      #2;
      m_reset();
      check_outputs("async_rst");
      #1 rst = 0;
      // table must be back at weakly not-taken
      lookup(32'h10, 1, 32'h40);
      cycle("post_rst");
      chk("post_rst_taken", bus.ifu_rsp_taken, 0);
      idle();

      // random traffic against the model
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] pc;
         pc = $urandom & 32'hFFFF_FFFC;
         bus.ifu_req_valid = ($urandom_range(0, 9) < 7);
         bus.ifu_req_pc    = pc;
         bus.ifu_req_bxx   = ($urandom_range(0, 9) < 6);
         bus.ifu_req_imm   = $urandom;
         bus.ifu_rsp_ready = ($urandom_range(0, 9) < 7);
         bus.bjp_prdt_en   = ($urandom_range(0, 9) < 5);
         bus.bjp_prdt_index = ($urandom_range(0, 9) < 3) ? pc[6:2] : 5'($urandom);
         bus.bjp_prdt_res  = ($urandom_range(0, 9) < 6);
         bus.bjp_prdt_flush = ($urandom_range(0, 99) < 5);
         bus.bjp_prdt_pc   = $urandom;
         bus.bpu_redirect_ready = ($urandom_range(0, 9) < 5);
         cycle("rnd");
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
